ss_ret_checker: RTL

Return-path consumer for the RAS shadow stack. Accepts committed call/return events from the commit stage. Calls push the return address onto the shadow stack. Returns pop it and compare it against the actual return target; a mismatch or an unexplained underflow raises a sticky control-flow violation. Calls arriving while the stack is full are tracked by an overflow counter, so their matching returns pass unchecked and the stack stays in sync.

---
 rtl/ss_pkg.sv | 14 +
 rtl/ss_sat_counter.sv | 24 ++
 rtl/ss_ret_checker.sv | 139 +++++++++++++
 3 files changed

// File: rtl/ss_pkg.sv
// Shared types and default widths for the return-address shadow-stack checker.
package ss_pkg;

    typedef enum logic [1:0] {
        SS_IDLE,
        SS_CHECK,
        SS_ALARM
    } ss_state_e;

    localparam int SS_ADDR_W = 64;
    localparam int SS_OVF_W  = 16;
    localparam int SS_CNT_W  = 32;

endpackage

// File: rtl/ss_sat_counter.sv
// Up/down counter that holds at zero and at all-ones instead of wrapping.
module ss_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    // NOTE: state registers are written with non-blocking assignments only, so every
    // always_ff reading them sees the pre-edge value regardless of evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (inc && !dec && (count != '1)) begin
            count <= count + 1'b1;
        end else if (dec && !inc && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/ss_ret_checker.sv
// Commit-stage return checker: pushes call return addresses to the shadow stack and
// compares popped addresses against actual return targets, flagging violations.
module ss_ret_checker
    import ss_pkg::*;
#(
    parameter int ADDR_W = SS_ADDR_W,
    parameter int OVF_W  = SS_OVF_W,
    parameter int CNT_W  = SS_CNT_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_evt_valid,
    output logic              o_evt_ready,
    input  logic              i_evt_call,
    input  logic              i_evt_ret,
    input  logic [ADDR_W-1:0] i_evt_addr,
    output logic              o_ss_push,
    output logic [ADDR_W-1:0] o_ss_data,
    input  logic              i_ss_full,
    output logic              o_ss_pop,
    input  logic [ADDR_W-1:0] i_ss_data,
    input  logic              i_ss_empty,
    output logic              o_violation,
    output logic [ADDR_W-1:0] o_viol_expected,
    output logic [ADDR_W-1:0] o_viol_actual,
    output logic              o_proto_err,
    input  logic              i_viol_clear,
    output logic [CNT_W-1:0]  o_chk_count,
    output logic [CNT_W-1:0]  o_unchk_count
);

    ss_state_e         state;
    logic [ADDR_W-1:0] exp_q;
    logic [ADDR_W-1:0] act_q;
    logic [OVF_W-1:0]  ovf_cnt;

    logic accept;
    logic is_call;
    logic is_ret;
    logic is_both;
    logic ovf_nz;
    logic ovf_inc;
    logic ovf_dec;
    logic underflow;

    assign o_evt_ready = (state == SS_IDLE);
    assign accept      = i_evt_valid & o_evt_ready;
    assign is_call     = accept & i_evt_call & ~i_evt_ret;
    assign is_ret      = accept & i_evt_ret & ~i_evt_call;
    assign is_both     = accept & i_evt_call & i_evt_ret;

    // Calls that find the stack full are remembered only as a count, so that their
    // returns can be skipped without popping someone else's entry.
    assign ovf_nz    = |ovf_cnt;
    assign ovf_inc   = is_call & i_ss_full;
    assign ovf_dec   = is_ret & ovf_nz;
    assign underflow = is_ret & ~ovf_nz & i_ss_empty;

    assign o_ss_push = is_call & ~i_ss_full;
    assign o_ss_data = o_ss_push ? i_evt_addr : '0;
    assign o_ss_pop  = is_ret & ~ovf_nz & ~i_ss_empty;

    ss_sat_counter #(
        .W (OVF_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .inc   (ovf_inc),
        .dec   (ovf_dec),
        .count (ovf_cnt)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state           <= SS_IDLE;
            exp_q           <= '0;
            act_q           <= '0;
            o_violation     <= 1'b0;
            o_viol_expected <= '0;
            o_viol_actual   <= '0;
            o_proto_err     <= 1'b0;
            o_chk_count     <= '0;
            o_unchk_count   <= '0;
        end else begin
            if (ovf_dec) begin
                o_unchk_count <= o_unchk_count + 1'b1;
            end

            case (state)
                SS_IDLE: begin
                    // A clear and a new protocol error in the same cycle leave the flag set.
                    if (i_viol_clear) begin
                        o_proto_err <= 1'b0;
                    end
                    if (is_both) begin
                        o_proto_err <= 1'b1;
                    end
                    if (underflow) begin
                        o_violation     <= 1'b1;
                        o_viol_expected <= '0;
                        o_viol_actual   <= i_evt_addr;
                        state           <= SS_ALARM;
                    end else if (o_ss_pop) begin
                        exp_q <= i_ss_data;
                        act_q <= i_evt_addr;
                        state <= SS_CHECK;
                    end
                end

                SS_CHECK: begin
                    o_chk_count <= o_chk_count + 1'b1;
                    if (exp_q == act_q) begin
                        state <= SS_IDLE;
                    end else begin
                        o_violation     <= 1'b1;
                        o_viol_expected <= exp_q;
                        o_viol_actual   <= act_q;
                        state           <= SS_ALARM;
                    end
                end

                SS_ALARM: begin
                    if (i_viol_clear) begin
                        o_violation     <= 1'b0;
                        o_viol_expected <= '0;
                        o_viol_actual   <= '0;
                        o_proto_err     <= 1'b0;
                        state           <= SS_IDLE;
                    end
                end

                default: begin
                    state <= SS_IDLE;
                end
            endcase
        end
    end

endmodule
